// File: rtl/uart_echo_responder.sv
// ============================================================================
// uart_echo_responder : buffers UART RX bytes in a FIFO and echoes them to TX
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_echo_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          rx_data,
  input  logic                           rx_vld,
  input  logic                           rx_err,
  input  logic                           tx_rfd,
  output logic [DATA_WIDTH-1:0]          tx_data,
  output logic                           tx_vld,
  output logic [$clog2(FIFO_DEPTH)+1:0]  level,
  output logic [CNT_WIDTH-1:0]           drop_cnt,
  output logic [CNT_WIDTH-1:0]           err_cnt,
  output logic                           busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = AW + 2;

  typedef enum logic [0:0] {
    ST_EMPTY   = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          count_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [LW-1:0]          level_q, level_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
  logic                   busy_q, busy_d;
  logic                   fifo_empty, fifo_full;
  logic                   wr_en, rd_en;

  // Full/empty come from pre-edge pointers, so a write while full is dropped
  // even if the output stage frees a slot in the same cycle.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign wr_en      = rx_vld && !rx_err && !fifo_full;

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (!fifo_empty) begin
          rd_en   = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (tx_rfd) begin
          if (!fifo_empty) rd_en   = 1'b1;
          else             state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (rd_en) tx_data_d = mem[rd_ptr_q[AW-1:0]];
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(wr_en);
    rd_ptr_d   = rd_ptr_q + PW'(rd_en);
    count_d    = wr_ptr_d - rd_ptr_d;
    level_d    = LW'(count_d) + LW'(state_d == ST_PRESENT);
    busy_d     = (state_d == ST_PRESENT) || (wr_ptr_d != rd_ptr_d);
    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    // Both counters saturate rather than wrap.
    if (rx_vld && rx_err && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + 1'b1;
    if (rx_vld && !rx_err && fifo_full && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_data_q  <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_data_q  <= tx_data_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
      busy_q     <= busy_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr_q[AW-1:0]] <= rx_data;
  end

  assign tx_data  = tx_data_q;
  assign tx_vld   = (state_q == ST_PRESENT);
  assign level    = level_q;
  assign drop_cnt = drop_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_echo_responder.sv
// ============================================================================
// tb_uart_echo_responder : directed scoreboard bench for uart_echo_responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_echo_responder;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_err;
  logic       tx_rfd;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic [5:0] level;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;
  logic       busy;

  // Second instance with 2-bit counters, fed the same traffic.
  logic [7:0] s_tx_data;
  logic       s_tx_vld;
  logic [5:0] s_level;
  logic [1:0] s_drop_cnt;
  logic [1:0] s_err_cnt;
  logic       s_busy;

  int n_tests;
  int n_fail;
  logic [7:0] exp_q[$];

  uart_echo_responder #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld), .rx_err(rx_err),
    .tx_rfd(tx_rfd), .tx_data(tx_data), .tx_vld(tx_vld), .level(level),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt), .busy(busy)
  );

  uart_echo_responder #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld), .rx_err(rx_err),
    .tx_rfd(tx_rfd), .tx_data(s_tx_data), .tx_vld(s_tx_vld), .level(s_level),
    .drop_cnt(s_drop_cnt), .err_cnt(s_err_cnt), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One clock cycle; any transfer in this cycle is scored at the negedge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (!rst && tx_vld === 1'b1 && tx_rfd) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL unexpected_tx: observed 0x%0h expected no transfer", tx_data);
      end else begin
        e = exp_q.pop_front();
        assert (tx_data === e) else begin
          n_fail++;
          $error("FAIL tx_order: observed 0x%0h expected 0x%0h", tx_data, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic err, input logic echo);
    rx_data = d;
    rx_err  = err;
    rx_vld  = 1'b1;
    if (echo) exp_q.push_back(d);
    tick();
    rx_vld  = 1'b0;
    rx_err  = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_vld"},   32'(tx_vld),   32'd0);
    chk({tag, "_tx_data"},  32'(tx_data),  32'd0);
    chk({tag, "_level"},    32'(level),    32'd0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    chk({tag, "_err_cnt"},  32'(err_cnt),  32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    rx_data = 8'h00;
    rx_vld  = 1'b0;
    rx_err  = 1'b0;
    tx_rfd  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals("reset");

    // Single echo: 2-cycle latency, one transfer, then idle.
    tx_rfd = 1'b1;
    send(8'h64, 1'b0, 1'b1);
    chk("echo_lat_n1_vld", 32'(tx_vld), 32'd0);
    chk("echo_lat_n1_level", 32'(level), 32'd1);
    tick();
    chk("echo_vld", 32'(tx_vld), 32'd1);
    chk("echo_data", 32'(tx_data), 32'h64);
    chk("echo_busy", 32'(busy), 32'd1);
    tick();
    chk("echo_done_vld", 32'(tx_vld), 32'd0);
    chk("echo_done_level", 32'(level), 32'd0);
    chk("echo_done_busy", 32'(busy), 32'd0);

    // Backpressure and ordering.
    tx_rfd = 1'b0;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 1'b1);
    chk("bp_vld", 32'(tx_vld), 32'd1);
    chk("bp_data", 32'(tx_data), 32'h01);
    chk("bp_level", 32'(level), 32'd5);
    tick();
    chk("bp_hold_data", 32'(tx_data), 32'h01);
    tx_rfd = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_drained_level", 32'(level), 32'd0);
    chk("bp_drained_vld", 32'(tx_vld), 32'd0);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Overflow: 20 bytes into a 17-byte capacity.
    tx_rfd = 1'b0;
    for (int i = 1; i <= 20; i++) send(8'(8'h10 + i), 1'b0, i <= 17);
    chk("ovf_level", 32'(level), 32'd17);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("ovf_head", 32'(tx_data), 32'h11);

    // Full plus simultaneous read: write still dropped.
    tx_rfd = 1'b1;
    send(8'hEE, 1'b0, 1'b0);
    chk("full_rd_level", 32'(level), 32'd16);
    chk("full_rd_drop_cnt", 32'(drop_cnt), 32'd4);
    chk("sat_drop_cnt", 32'(s_drop_cnt), 32'd3);
    for (int i = 0; i < 16; i++) tick();
    chk("ovf_drained_level", 32'(level), 32'd0);
    chk("ovf_queue_empty", 32'(exp_q.size()), 32'd0);

    // Error bytes are counted, not echoed; narrow counter saturates.
    for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 1'b1, 1'b0);
    chk("err_cnt3", 32'(err_cnt), 32'd3);
    chk("sat_err_cnt3", 32'(s_err_cnt), 32'd3);
    tick();
    tick();
    chk("err_no_vld", 32'(tx_vld), 32'd0);
    chk("err_level", 32'(level), 32'd0);
    for (int i = 0; i < 2; i++) send(8'hB0 + 8'(i), 1'b1, 1'b0);
    chk("err_cnt5", 32'(err_cnt), 32'd5);
    chk("sat_err_cnt5", 32'(s_err_cnt), 32'd3);

    // Reset mid-stream with a byte presented during reset.
    tx_rfd = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 1'b0, 1'b1);
    chk("pre_rst_level", 32'(level), 32'd8);
    rst     = 1'b1;
    rx_vld  = 1'b1;
    rx_data = 8'hAB;
    tick();
    rst     = 1'b0;
    rx_vld  = 1'b0;
    rx_data = 8'h00;
    exp_q.delete();
    chk_reset_vals("midrst");
    tx_rfd = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_no_echo_vld", 32'(tx_vld), 32'd0);
    chk("midrst_no_echo_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/uart_echo_responder.md
# uart_echo_responder

Far-end responder for UART link testing. It takes received bytes from a UART core's RX interface (`dout`/`dout_vld`/`rx_err`), buffers them in a small FIFO, and drives them back into the same core's TX interface (`din`/`din_vld`/`rfd`) unchanged. It replaces the bare `dout`→`din` loopback wiring on the responder side with flow control, overflow and error accounting, so the initiating UART can stream bytes back-to-back without losing echoes silently.

## Interface
Parameters:
- `DATA_WIDTH`, 8: byte width. Must match the UART `DI_WIDTH`/`DO_WIDTH`.
- `FIFO_DEPTH`, 16: FIFO entries. Power of 2, ≥ 2.
- `CNT_WIDTH`, 16: width of the drop and error counters.

Ports:
- `clk`  in  1: single clock, shared with the attached UART.
- `rst`  in  1: synchronous, active-high reset.
- `rx_data`  in  DATA_WIDTH: received byte (UART `dout`).
- `rx_vld`  in  1: one-cycle pulse per received byte (UART `dout_vld`).
- `rx_err`  in  1: frame/parity error flag. Qualified by `rx_vld` (UART `rx_err`).
- `tx_rfd`  in  1: UART TX ready for data (UART `rfd`).
- `tx_data`  out  DATA_WIDTH: byte to transmit (UART `din`).
- `tx_vld`  out  1: `tx_data` valid (UART `din_vld`).
- `level`  out  $clog2(FIFO_DEPTH)+2: bytes held, FIFO plus output register, 0..FIFO_DEPTH+1.
- `drop_cnt`  out  CNT_WIDTH: good bytes dropped because the FIFO was full.
- `err_cnt`  out  CNT_WIDTH: bytes discarded because of `rx_err`.
- `busy`  out  1: `tx_vld` | FIFO not empty.

## Operation
- **Storage.** Circular FIFO with `wr_ptr`/`rd_ptr` of $clog2(FIFO_DEPTH)+1 bits (extra wrap bit).
  - empty = pointers equal.
  - full = low bits equal and wrap bits differ.
  - Pointers wrap naturally modulo 2·FIFO_DEPTH.
- **Output register.** `tx_data`/`tx_vld` form a one-entry output stage. States:
  - EMPTY (`tx_vld`=0): load from the FIFO head when the FIFO is not empty, then go to PRESENT.
  - PRESENT (`tx_vld`=1): hold `tx_data` stable until transfer.
- **Transfer.** A transfer occurs in a cycle where `tx_vld` & `tx_rfd`. On transfer:
  - if the FIFO is not empty, reload from the head (stay PRESENT, back-to-back);
  - otherwise go to EMPTY.
- **Ingress**, evaluated each cycle with `rx_vld`=1:
  - `rx_err`=1: byte discarded, `err_cnt`+1.
  - `rx_err`=0 and FIFO not full: write `rx_data`, `wr_ptr`+1.
  - `rx_err`=0 and FIFO full: byte discarded, `drop_cnt`+1.
- **Full is pre-edge state.** A write while full is dropped even if a read frees a slot in the same cycle.
- **Simultaneous write and read**, not full: both happen, and `level` is unchanged when the output stage stays PRESENT.
- **Write into an empty FIFO.** The output stage never bypasses the FIFO. The byte is loaded on the following edge.
- **Counters.** Both saturate at all-ones and never wrap. `rx_data` is ignored when `rx_vld`=0.
- **Reset.** `rst` high at any point, including mid-stream:
  - pointers cleared, output stage EMPTY;
  - all buffered bytes lost;
  - a byte presented while `rst`=1 is ignored;
  - memory contents are not cleared.

## Timing
- Reset values: `tx_vld`=0, `tx_data`=0, `level`=0, `drop_cnt`=0, `err_cnt`=0, `busy`=0.
- Latency, idle block: `rx_vld` high in cycle N → FIFO write at edge ending N → output load at edge ending N+1 → `tx_vld`=1 in cycle N+2.
- Throughput: one transfer per cycle while `tx_rfd`=1 and data is available. One ingress byte per cycle.
- `tx_data` must not change while `tx_vld`=1 and `tx_rfd`=0.
- `level`, `busy` and the counters are registered and reflect state after the current edge.
- Capacity is FIFO_DEPTH+1 bytes. `level` = FIFO count + `tx_vld`.

## Test plan
- **Single echo.** Reset, `tx_rfd`=1, `rx_vld` pulse with 0x64 in cycle N → `tx_vld`=1, `tx_data`=0x64 in cycle N+2; one transfer; `level` returns to 0; `busy`=0.
- **Backpressure and ordering.** `tx_rfd`=0, push 0x01..0x05 in consecutive cycles → `tx_vld`=1, `tx_data` held at 0x01, `level`=5. Raise `tx_rfd` → 0x01..0x05 transferred in order on consecutive cycles.
- **Overflow.** `tx_rfd`=0, DEPTH=16, push 20 good bytes → `level`=17, `drop_cnt`=3. The drained sequence is bytes 1..17.
- **Full plus simultaneous read.** With `level`=17 and FIFO full, one cycle with `rx_vld`=1 and `tx_rfd`=1 → byte dropped, `drop_cnt`+1, `level`=16.
- **Error and saturation.** Three `rx_vld` pulses with `rx_err`=1 → `err_cnt`=3, no `tx_vld`. With CNT_WIDTH=2, five errors → `err_cnt`=3.
- **Reset mid-stream.** 8 bytes buffered, `tx_rfd`=0, assert `rst` for 1 cycle with `rx_vld`=1 → next cycle all outputs are at reset values. The byte presented during reset is not echoed.
